// File: rtl/usb_dpdm_tx.sv
// USB bus-side transmit encoder: SYNC prefix, NRZI data to J/K on dp/dm, SE0/J EOP.
// Optional USB_DPDM_TX_ABORT_EN adds an abort input that replaces the rest of the packet with 8 J symbols.
module usb_dpdm_tx #(
  parameter int SYNC_LEN    = 8,
  parameter int EOP_SE0_LEN = 2,
  parameter int LOW_SPEED   = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic in_bit,
  input  logic nrzi_sending,
`ifdef USB_DPDM_TX_ABORT_EN
  input  logic abort,
`endif
  output logic dp,
  output logic dm,
  output logic oe,
  output logic busy,
  output logic out_done
);

  localparam int CW = $clog2(SYNC_LEN + 16);

  // SYNC is K,J pairs ending in K,K; sent LSB first so bit i of this word goes out i-th.
  function automatic logic [SYNC_LEN-1:0] sync_pattern();
    logic [SYNC_LEN-1:0] p;
    p = '0;
    for (int i = 0; i < SYNC_LEN - 2; i++) p[i] = i[0];
    return p;
  endfunction

  localparam logic [SYNC_LEN-1:0] SYNC_PAT   = sync_pattern();
  localparam logic [1:0]          SYM_J      = (LOW_SPEED != 0) ? 2'b01 : 2'b10;
  localparam logic [1:0]          SYM_K      = ~SYM_J;
  localparam logic [1:0]          SYM_SE0    = 2'b00;
  localparam logic [CW-1:0]       FLUSH_LAST = CW'(SYNC_LEN - 1);
  localparam logic [CW-1:0]       SE0_LAST   = CW'(EOP_SE0_LEN - 1);
`ifdef USB_DPDM_TX_ABORT_EN
  localparam logic [CW-1:0]       ABORT_LAST = CW'(7);
`endif

  // The state register names what is on the bus during the current cycle.
  typedef enum logic [2:0] {
    IDLE,
    SEND,
    FLUSH,
    EOP_SE0,
    EOP_J
`ifdef USB_DPDM_TX_ABORT_EN
    , ABORT
`endif
  } state_t;

  state_t              state;
  logic [SYNC_LEN-1:0] sr;
  logic [CW-1:0]       cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= SYNC_PAT;
      cnt      <= '0;
      dp       <= 1'b0;
      dm       <= 1'b0;
      oe       <= 1'b0;
      busy     <= 1'b0;
      out_done <= 1'b0;
    end else begin
      out_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (nrzi_sending) begin
            state     <= SEND;
            {dp, dm}  <= sr[0] ? SYM_J : SYM_K;
            sr        <= {in_bit, sr[SYNC_LEN-1:1]};
            oe        <= 1'b1;
            busy      <= 1'b1;
          end else begin
            sr        <= SYNC_PAT;
            {dp, dm}  <= SYM_SE0;
            oe        <= 1'b0;
            busy      <= 1'b0;
          end
        end

        SEND: begin
`ifdef USB_DPDM_TX_ABORT_EN
          if (abort) begin
            state    <= ABORT;
            {dp, dm} <= SYM_J;
            sr       <= SYNC_PAT;
            cnt      <= '0;
          end else
`endif
          begin
            {dp, dm} <= sr[0] ? SYM_J : SYM_K;
            if (nrzi_sending) begin
              sr <= {in_bit, sr[SYNC_LEN-1:1]};
            end else begin
              // This edge already drains the first of the SYNC_LEN buffered bits.
              state <= FLUSH;
              sr    <= {1'b1, sr[SYNC_LEN-1:1]};
              cnt   <= '0;
            end
          end
        end

        FLUSH: begin
`ifdef USB_DPDM_TX_ABORT_EN
          if (abort) begin
            state    <= ABORT;
            {dp, dm} <= SYM_J;
            sr       <= SYNC_PAT;
            cnt      <= '0;
          end else
`endif
          if (cnt == FLUSH_LAST) begin
            state    <= EOP_SE0;
            {dp, dm} <= SYM_SE0;
            cnt      <= '0;
          end else begin
            {dp, dm} <= sr[0] ? SYM_J : SYM_K;
            sr       <= {1'b1, sr[SYNC_LEN-1:1]};
            cnt      <= cnt + 1'b1;
          end
        end

        EOP_SE0: begin
          if (cnt == SE0_LAST) begin
            state    <= EOP_J;
            {dp, dm} <= SYM_J;
            out_done <= 1'b1;
            cnt      <= '0;
          end else begin
            {dp, dm} <= SYM_SE0;
            cnt      <= cnt + 1'b1;
          end
        end

        EOP_J: begin
          state    <= IDLE;
          {dp, dm} <= SYM_SE0;
          oe       <= 1'b0;
          busy     <= 1'b0;
          sr       <= SYNC_PAT;
          cnt      <= '0;
        end

`ifdef USB_DPDM_TX_ABORT_EN
        ABORT: begin
          if (cnt == ABORT_LAST) begin
            state    <= EOP_SE0;
            {dp, dm} <= SYM_SE0;
            cnt      <= '0;
          end else begin
            {dp, dm} <= SYM_J;
            cnt      <= cnt + 1'b1;
          end
        end
`endif

        default: begin
          state    <= IDLE;
          {dp, dm} <= SYM_SE0;
          oe       <= 1'b0;
          busy     <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule
